// File: rtl/bin_mul_pkg.sv
// Shared definitions for the multiplier issue stage: FSM encoding,
// default core latency and the product-width helper.
package bin_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int LAT_DEF = 4;

    // Signed W x W product needs 2*W-1 bits except for MIN*MIN.
    function automatic int pw_of(input int w);
        return 2 * w - 1;
    endfunction

endpackage

// File: rtl/bin_mul_lat_cnt.sv
// Clearable up-counter that tracks how long operands have been held on
// the core; term flags that the core pipeline has fully settled.
module bin_mul_lat_cnt #(
    parameter int LAT  = 4,
    parameter int CW   = $clog2(LAT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic term
);

    logic [CW-1:0] cnt;

    assign term = (cnt == CW'(LAT));

    // Clear on accept, count while holding; stop at LAT so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !term)
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/bin_mul_issue_ctrl.sv
// Operand issue / result capture stage in front of the pipelined signed
// array multiplier. Holds one operand pair stable on the core for the
// whole pipeline depth, then captures and returns the product.
module bin_mul_issue_ctrl
    import bin_mul_pkg::*;
#(
    parameter int W     = 3,
    parameter int PW    = pw_of(W),
    parameter int LAT   = LAT_DEF,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    output logic             mul_en,
    input  logic [PW-1:0]    mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PW-1:0]    out_p,
    output logic             out_ovf,
    output logic [CNT_W-1:0] op_count
);

    // Most negative operand; MIN*MIN is the only product that does not fit in PW bits.
    localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

    state_t state, state_nxt;
    logic   accept, capture, retire, lat_done, ovf_r;

    bin_mul_lat_cnt #(.LAT(LAT)) u_lat_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (state == ST_HOLD),
        .term  (lat_done)
    );

    // Handshake qualifiers and next-state decode; DONE can retire and accept in one edge.
    always_comb begin
        state_nxt = state;
        in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
        mul_en    = (state == ST_HOLD);
        accept    = in_valid && in_ready;
        capture   = (state == ST_HOLD) && lat_done;
        retire    = (state == ST_DONE) && out_ready;
        case (state)
            ST_IDLE: if (in_valid)  state_nxt = ST_HOLD;
            ST_HOLD: if (lat_done)  state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = in_valid ? ST_HOLD : ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Operand latch on accept, result capture once the core has settled, result retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a     <= '0;
            mul_b     <= '0;
            ovf_r     <= 1'b0;
            out_p     <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                mul_a <= in_a;
                mul_b <= in_b;
                ovf_r <= (in_a == MIN) && (in_b == MIN);
            end
            if (capture) begin
                out_p     <= mul_p;
                out_ovf   <= ovf_r;
                out_valid <= 1'b1;
            end else if (retire) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Completed-handshake counter, saturating at all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            op_count <= '0;
        else if (retire && (op_count != {CNT_W{1'b1}}))
            op_count <= op_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_bin_mul_issue_ctrl.sv
// Bench for bin_mul_issue_ctrl: a behavioural LAT-deep registered multiplier
// sits behind each stage instance. A second instance with CNT_W=2 shares the
// stimulus to exercise op_count saturation.
module tb_bin_mul_issue_ctrl;

    localparam int W   = 3;
    localparam int PW  = 5;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          in_valid, out_ready;
    logic [W-1:0]  in_a, in_b;

    logic          in_ready, mul_en, out_valid, out_ovf;
    logic [W-1:0]  mul_a, mul_b;
    logic [PW-1:0] mul_p, out_p;
    logic [7:0]    op_count;

    logic          in_ready2, mul_en2, out_valid2, out_ovf2;
    logic [W-1:0]  mul_a2, mul_b2;
    logic [PW-1:0] mul_p2, out_p2;
    logic [1:0]    op_count2;

    bin_mul_issue_ctrl #(.W(W), .PW(PW), .LAT(LAT), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en),
        .mul_p(mul_p), .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .out_ovf(out_ovf), .op_count(op_count)
    );

    bin_mul_issue_ctrl #(.W(W), .PW(PW), .LAT(LAT), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .mul_a(mul_a2), .mul_b(mul_b2), .mul_en(mul_en2),
        .mul_p(mul_p2), .out_valid(out_valid2), .out_ready(out_ready),
        .out_p(out_p2), .out_ovf(out_ovf2), .op_count(op_count2)
    );

    // Core stand-in: product truncated to PW bits, LAT register stages.
    function automatic logic [PW-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [PW-1:0] sa, sb;
        sa = PW'($signed(a));
        sb = PW'($signed(b));
        return sa * sb;
    endfunction

    logic [PW-1:0] pipe1 [LAT];
    logic [PW-1:0] pipe2 [LAT];
    always_ff @(posedge clk) begin
        pipe1[0] <= prod(mul_a, mul_b);
        pipe2[0] <= prod(mul_a2, mul_b2);
        for (int i = 1; i < LAT; i++) begin
            pipe1[i] <= pipe1[i-1];
            pipe2[i] <= pipe2[i-1];
        end
    end
    assign mul_p  = pipe1[LAT-1];
    assign mul_p2 = pipe2[LAT-1];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One full operation: accept, wait for the result, retire it.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [PW-1:0] p, output logic ovf, output int lat);
        int g;
        @(negedge clk);
        in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
        g = 0;
        while (!in_ready && g < 20) begin @(negedge clk); g++; end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        p = out_p; ovf = out_ovf;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0]  a, b;
        logic [PW-1:0] p;
        logic          ovf;
        logic [7:0]    cnt;
        logic [1:0]    cnt2;
    } vec_t;

    vec_t tbl [5];

    logic [PW-1:0] p, p0;
    logic          ovf;
    int            lat, bp_err, stab_err, ri, si, cyc, g;
    logic [7:0]    c0;
    logic [W-1:0]  sa [3], sb [3], ha, hb;
    logic [PW-1:0] sp [3];
    int            rc [3];

    initial begin
        tbl[0] = '{3'd2, 3'd2, 5'd4,       1'b0, 8'd1, 2'd1};
        tbl[1] = '{3'd3, 3'b110, 5'b11010, 1'b0, 8'd2, 2'd2};
        tbl[2] = '{3'b100, 3'b100, 5'b10000, 1'b1, 8'd3, 2'd3};
        tbl[3] = '{3'b100, 3'd3, 5'b10100, 1'b0, 8'd4, 2'd3};
        tbl[4] = '{3'd1, 3'b111, 5'b11111, 1'b0, 8'd5, 2'd3};
        sa[0] = 3'd1; sb[0] = 3'd1;   sp[0] = 5'd1;
        sa[1] = 3'd2; sb[1] = 3'b101; sp[1] = 5'b11010;
        sa[2] = 3'b111; sb[2] = 3'b111; sp[2] = 5'd1;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        #12;
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_mul_en", 32'(mul_en), 0);
        chk("reset_op_count", 32'(op_count), 0);
        chk("reset_out_p", 32'(out_p), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 1);

        // Basic: 3 * -2
        run_op(3'd3, 3'b110, p, ovf, lat);
        chk("basic_latency", 32'(lat), 5);
        chk("basic_p", 32'(p), 32'h1a);
        chk("basic_ovf", 32'(ovf), 0);
        chk("basic_count", 32'(op_count), 1);

        // Overflow pair then its neighbour
        run_op(3'b100, 3'b100, p, ovf, lat);
        chk("ovf_p", 32'(p), 32'h10);
        chk("ovf_flag", 32'(ovf), 1);
        run_op(3'b100, 3'd3, p, ovf, lat);
        chk("min3_p", 32'(p), 32'h14);
        chk("min3_ovf", 32'(ovf), 0);

        // Backpressure: result held 10 cycles, a waiting pair must not be taken
        @(negedge clk);
        in_a = 3'd1; in_b = 3'b101; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_a = 3'd2; in_b = 3'd2;
        g = 0;
        while (!out_valid && g < 20) begin @(negedge clk); g++; end
        chk("bp_valid", 32'(out_valid), 1);
        p0 = out_p;
        chk("bp_p", 32'(p0), 32'h1d);
        bp_err = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_p !== p0 || in_ready !== 1'b0 || out_valid !== 1'b1) bp_err++;
        end
        chk("bp_stable", 32'(bp_err), 0);
        c0 = op_count;
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_count", 32'(op_count), 32'(c0 + 8'd1));
        chk("bp_retired", 32'(out_valid), 0);
        chk("bp_idle_ready", 32'(in_ready), 1);

        // Back-to-back stream with out_ready held high
        out_ready = 1'b1;
        ri = 0; si = 0; cyc = 0; stab_err = 0; ha = '0; hb = '0;
        while (ri < 3 && cyc < 60) begin
            @(negedge clk);
            if (mul_en && (mul_a !== ha || mul_b !== hb)) stab_err++;
            if (out_valid) begin
                chk("b2b_p", 32'(out_p), 32'(sp[ri]));
                rc[ri] = cyc;
                ri++;
            end
            if (si < 3) begin
                in_valid = 1'b1; in_a = sa[si]; in_b = sb[si];
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready) begin
                ha = sa[si]; hb = sb[si]; si++;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_results", 32'(ri), 3);
        chk("b2b_gap1", 32'(rc[1] - rc[0]), 6);
        chk("b2b_gap2", 32'(rc[2] - rc[1]), 6);
        chk("b2b_stable", 32'(stab_err), 0);

        // Reset in the middle of HOLD (cnt==2)
        @(negedge clk);
        in_a = 3'd3; in_b = 3'd3; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_hold", 32'(mul_en), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mul_a", 32'(mul_a), 0);
        chk("rst_mul_b", 32'(mul_b), 0);
        chk("rst_mul_en", 32'(mul_en), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_p", 32'(out_p), 0);
        chk("rst_op_count", 32'(op_count), 0);
        chk("rst_op_count2", 32'(op_count2), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: first entry is the post-reset (2,2) op; dut2 saturates at 3
        for (int i = 0; i < 5; i++) begin
            run_op(tbl[i].a, tbl[i].b, p, ovf, lat);
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 5);
            chk($sformatf("tbl%0d_p", i), 32'(p), 32'(tbl[i].p));
            chk($sformatf("tbl%0d_ovf", i), 32'(ovf), 32'(tbl[i].ovf));
            chk($sformatf("tbl%0d_cnt", i), 32'(op_count), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_cnt_sat", i), 32'(op_count2), 32'(tbl[i].cnt2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
